// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the write-through data cache.
//   state_t     : controller states (IDLE, REFILL, WRITE)
//   OFFSET_W    : byte-offset bits within a one-word line
//   TAG_W       : tag width for the default geometry
//   byte_enable : byte-lane mask for a word or single-byte store
package dcache_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int INDEX_W_DEF    = 5;
    localparam int OFFSET_W       = 2;
    localparam int TAG_W          = DATA_WIDTH_DEF - INDEX_W_DEF - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    // Word accesses enable all four lanes; byte accesses enable only the
    // lane selected by the low address bits.
    function automatic logic [3:0] byte_enable(input logic is_byte,
                                               input logic [OFFSET_W-1:0] offset);
        logic [3:0] be;
        if (is_byte) begin
            be = 4'b0001 << offset;
        end else begin
            be = 4'hF;
        end
        return be;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage for a direct-mapped, one-word-line cache.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (clears valid bits only)
//   i_rd_index    : combinational read index
//   o_rd_valid    : valid bit of the addressed line
//   o_rd_tag      : stored tag of the addressed line
//   o_rd_data     : stored data word of the addressed line
//   i_wr_en       : write strobe
//   i_wr_index    : line to write
//   i_wr_fill     : 1 = refill (also write tag and set valid)
//   i_wr_tag      : tag written on refill
//   i_wr_be       : byte-lane enables for the data write
//   i_wr_data     : lane-aligned write data
module dcache_array #(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_W    = 5,
    parameter int TAG_W      = 25
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INDEX_W-1:0]      i_rd_index,
    output logic                    o_rd_valid,
    output logic [TAG_W-1:0]        o_rd_tag,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    input  logic                    i_wr_en,
    input  logic [INDEX_W-1:0]      i_wr_index,
    input  logic                    i_wr_fill,
    input  logic [TAG_W-1:0]        i_wr_tag,
    input  logic [DATA_WIDTH/8-1:0] i_wr_be,
    input  logic [DATA_WIDTH-1:0]   i_wr_data
);
    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en && i_wr_fill) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tags are only meaningful behind a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (i_wr_en && i_wr_fill) begin
            r_tag[i_wr_index] <= i_wr_tag;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];

    // One storage array per byte lane so each lane has a single writer.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_lane
            logic [7:0] r_lane [LINES];

            always_ff @(posedge clk) begin
                if (i_wr_en && i_wr_be[gi]) begin
                    r_lane[i_wr_index] <= i_wr_data[gi*8 +: 8];
                end
            end

            assign o_rd_data[gi*8 +: 8] = r_lane[i_rd_index];
        end
    endgenerate

endmodule

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   cpu_req_i    : memory-stage access valid
//   cpu_we_i     : 1 = store, 0 = load
//   cpu_byte_i   : 1 = byte access, 0 = word access
//   cpu_addr_i   : byte address
//   cpu_wdata_i  : store data (byte stores use [7:0])
//   cpu_rdata_o  : load data (combinational on a hit)
//   cpu_stall_o  : memory stage must hold
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o : backing request
//   mem_rdata_i  : refill word
//   mem_ack_i    : one-cycle completion pulse
module dcache_wt
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int INDEX_W    = INDEX_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic                  cpu_byte_i,
    input  logic [DATA_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);
    localparam int TAG_WIDTH = DATA_WIDTH - INDEX_W - OFFSET_W;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [OFFSET_W-1:0]     w_offset;
    logic [INDEX_W-1:0]      w_index;
    logic [TAG_WIDTH-1:0]    w_tag;
    logic                    w_rd_valid;
    logic [TAG_WIDTH-1:0]    w_rd_tag;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic                    w_hit;

    logic                    w_stall;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_launch;
    logic                    w_fill;
    logic                    w_store_hit;

    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [DATA_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic [3:0]              r_mem_be;
    logic                    r_hit;
    logic [INDEX_W-1:0]      r_index;
    logic [TAG_WIDTH-1:0]    r_tag;

    assign w_offset = cpu_addr_i[OFFSET_W-1:0];
    assign w_index  = cpu_addr_i[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign w_tag    = cpu_addr_i[DATA_WIDTH-1:INDEX_W+OFFSET_W];

    dcache_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .INDEX_W    (INDEX_W),
        .TAG_W      (TAG_WIDTH)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_index (w_index),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_fill | w_store_hit),
        .i_wr_index (r_index),
        .i_wr_fill  (w_fill),
        .i_wr_tag   (r_tag),
        .i_wr_be    (w_fill ? 4'hF : r_mem_be),
        .i_wr_data  (w_fill ? mem_rdata_i : r_mem_wdata)
    );

    assign w_hit     = w_rd_valid && (w_rd_tag == w_tag);
    assign w_shifted = w_rd_data >> {w_offset, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_rdata      = '0;
        w_fill       = 1'b0;
        w_store_hit  = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_req_i) begin
                    if (cpu_we_i) begin
                        w_stall      = 1'b1;
                        w_state_next = WRITE;
                    end else if (!w_hit) begin
                        w_stall      = 1'b1;
                        w_state_next = REFILL;
                    end else if (cpu_byte_i) begin
                        w_rdata = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
                    end else begin
                        w_rdata = w_rd_data;
                    end
                end
            end
            REFILL: begin
                w_stall = 1'b1;
                if (mem_ack_i) begin
                    w_fill       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            WRITE: begin
                w_stall = 1'b1;
                if (mem_ack_i) begin
                    // Hit status is the one captured when the store left IDLE.
                    w_store_hit  = r_hit;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_launch = (r_state == IDLE) && (w_state_next != IDLE);

    // Request latches: captured once when IDLE is left so the CPU side may
    // wander during the stall without disturbing the backing transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= 4'h0;
            r_hit       <= 1'b0;
            r_index     <= '0;
            r_tag       <= '0;
        end else if (w_launch) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= cpu_we_i;
            r_mem_addr <= {cpu_addr_i[DATA_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
            r_mem_be   <= cpu_we_i ? byte_enable(cpu_byte_i, w_offset) : 4'hF;
            r_hit      <= w_hit;
            r_index    <= w_index;
            r_tag      <= w_tag;
            if (cpu_we_i) begin
                r_mem_wdata <= cpu_byte_i ? {(DATA_WIDTH/8){cpu_wdata_i[7:0]}}
                                          : cpu_wdata_i;
            end
        end else if (r_state != IDLE && mem_ack_i) begin
            r_mem_req <= 1'b0;
        end
    end

    // The FSM is already forced to IDLE by reset; the gate also hides a
    // request presented while reset is held.
    assign cpu_stall_o = w_stall & ~rst;
    assign cpu_rdata_o = rst ? '0 : w_rdata;

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_be_o    = r_mem_be;

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipelined CPU's memory stage and the backing data memory, and acts as the responder to the CPU's load/store interface: address, write data, write enable, byte-op in; read data out.
- Adds a stall output so the memory stage can hold on misses and writes.
- Refills and write-throughs use a req/ack handshake to backing memory.

Parameters:
DATA_WIDTH, 32, data/address width
INDEX_W, 5, index bits; 2**INDEX_W one-word lines (32 lines)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
cpu_req_i  in  1  memory-stage access valid
cpu_we_i  in  1  1 = store, 0 = load
cpu_byte_i  in  1  1 = byte access, 0 = word access
cpu_addr_i  in  DATA_WIDTH  byte address
cpu_wdata_i  in  DATA_WIDTH  store data (byte stores use bits [7:0])
cpu_rdata_o  out  DATA_WIDTH  load data
cpu_stall_o  out  1  CPU must hold memory stage and inputs stable
mem_req_o  out  1  backing-memory request
mem_we_o  out  1  backing-memory write
mem_addr_o  out  DATA_WIDTH  word-aligned backing address
mem_wdata_o  out  DATA_WIDTH  backing write data, byte-lane aligned
mem_be_o  out  4  byte enables
mem_rdata_i  in  DATA_WIDTH  refill word
mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Address split:
  - offset = addr[1:0]
  - index = addr[INDEX_W+1:2]
  - tag = addr[DATA_WIDTH-1:INDEX_W+2]
  - hit = valid[index] && tag_store[index] == tag
- FSM states: IDLE, REFILL, WRITE.
- Reset (async): state IDLE; all valid bits 0; mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o = 0. cpu_stall_o and cpu_rdata_o evaluate to 0 while in reset.
- IDLE, cpu_req_i = 0: stall 0, rdata 0, no transition.
- IDLE, load hit:
  - cpu_rdata_o is combinational, same cycle; stall 0.
  - Word load: full line.
  - Byte load: byte at offset, zero-extended to 32 bits.
- IDLE, load miss:
  - stall 1 combinationally in the same cycle.
  - Next edge: go to REFILL. Latch the word-aligned address, index and tag; mem_req_o=1, mem_we_o=0, mem_be_o=4'hF.
- REFILL:
  - stall 1; request outputs held stable until mem_ack_i.
  - On ack: write mem_rdata_i into the line, set tag and valid, drop mem_req_o, go to IDLE.
  - The following cycle is a hit, stall 0.
  - Minimum miss penalty: 2 stall cycles.
- IDLE, store (hit or miss):
  - stall 1 in the same cycle.
  - Next edge: go to WRITE with mem_req_o=1, mem_we_o=1.
  - Word store: mem_be_o=4'hF, mem_wdata_o=cpu_wdata_i.
  - Byte store: mem_be_o = 1<<offset, wdata byte replicated to all four lanes.
  - The hit flag is latched at request time.
- WRITE:
  - stall 1; outputs held until ack.
  - On ack: if the latched hit was set, update only the enabled byte lanes of the line. Then go to IDLE, which releases the stall.
  - Store miss does not allocate and valid is unchanged.
  - Minimum store latency: 2 stall cycles.
- mem_ack_i seen in IDLE is ignored.
- A new CPU request is evaluated only in IDLE. When the stall drops, the CPU must not re-present the same access; an unchanged request in the cycle after completion is treated as a new access.
- Address index wraps naturally.
- Two addresses with the same index and different tags evict each other on refill.
- Reset mid-REFILL/WRITE: the transaction is abandoned, mem_req_o drops immediately, and no line is updated.
- cpu_* inputs are sampled when IDLE is left. Changes during stall are ignored because latched copies drive the mem_* outputs.

Decomposition:
- Package dcache_pkg:
  - state enum (IDLE, REFILL, WRITE)
  - localparams OFFSET_W=2, TAG_W = DATA_WIDTH-INDEX_W-2
  - helper for byte-enable generation
- One sub-module dcache_array:
  - holds valid, tag and data arrays
  - asynchronous read by index
  - synchronous write with byte enables
  - async clear of valid bits
- The FSM and the request latches stay in dcache_wt.

Test Plan:
- Cold load of word at 0x0000_0010 with backing word 0xDEADBEEF, ack after 3 cycles -> stall high 4 cycles, mem_addr_o=0x10, then rdata=0xDEADBEEF with stall 0; repeat load is a 0-stall hit.
- After that refill, byte load from 0x0000_0012 -> rdata=0x000000AD, stall 0, mem_req_o stays 0.
- Byte store 0x55 to 0x0000_0011 (hit) -> mem_be_o=4'b0010, mem_wdata_o=0x55555555; after ack a word load of 0x10 returns 0xDEAD55EF.
- Word store to 0x0000_0080 (miss) -> write-through with be 4'hF; a subsequent load of 0x80 misses and triggers a refill (no allocate).
- Load 0x0000_0010, then 0x0000_0090 (same index 4, different tag), then 0x10 again -> three refills; the final rdata equals the backing value.
- Assert rst for 1 cycle during REFILL before ack -> mem_req_o=0 immediately; a later load of the same address misses and refills.
